// File: rtl/mmu_pkg.sv
// Shared types and helpers for the matrix multiply unit feeders.
package mmu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } skew_state_t;

  // Drain counter must hold LENGTH-1 and still compare against 1.
  function automatic int cnt_width(input int length);
    return $clog2(length) + 1;
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth register chain for one skewer lane; all stages move together on shift.
module skew_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             shift_en_i,
  input  logic [WIDTH-1:0] head_i,
  output logic [WIDTH-1:0] tail_o
);

  logic [DEPTH-1:0][WIDTH-1:0] stage_q, stage_d;

  always_comb begin
    stage_d = stage_q;
    if (shift_en_i) begin
      stage_d[0] = head_i;
      for (int k = 1; k < DEPTH; k++) begin
        stage_d[k] = stage_q[k-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign tail_o = stage_q[DEPTH-1];

endmodule

// File: rtl/systolic_input_skewer.sv
// Diagonal input skewer for the systolic array: lane i lags lane 0 by i advances,
// with a zero flush after the last vector and a matching array enable.
module systolic_input_skewer
  import mmu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int LENGTH = 256
) (
  input  logic                          CLK,
  input  logic                          SYNC_RST,
  input  logic                          In_Valid,
  output logic                          In_Ready,
  input  logic                          In_Last,
  input  logic [0:LENGTH-1][WIDTH-1:0]  In_Data,
  input  logic                          Stall,
  output logic [0:LENGTH-1][WIDTH-1:0]  Out_Data,
  output logic                          Out_Valid,
  output logic                          Busy,
  output logic                          Done
);

  localparam int CNT_W = cnt_width(LENGTH);

  skew_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q;
  logic             done_q, done_d;
  logic             accept;
  logic             advance;
  logic [WIDTH-1:0] head [LENGTH];
  logic [WIDTH-1:0] tail [LENGTH];

  assign In_Ready = ~Stall & (state_q != DRAIN);
  assign accept   = In_Valid & In_Ready;
  assign advance  = accept | ((state_q == DRAIN) & ~Stall);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (accept) begin
      if (!In_Last) begin
        state_d = STREAM;
      end else if (LENGTH > 1) begin
        state_d = DRAIN;
        cnt_d   = CNT_W'(LENGTH - 1);
      end else begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end else if (advance) begin
      // Without an accept, only a DRAIN flush step can advance.
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (SYNC_RST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= advance;
      done_q      <= done_d;
    end
  end

  always_comb begin
    for (int i = 0; i < LENGTH; i++) begin
      head[i] = accept ? In_Data[i] : '0;
    end
  end

  for (genvar i = 0; i < LENGTH; i++) begin : g_lane
    skew_delay_line #(
      .WIDTH (WIDTH),
      .DEPTH (i + 1)
    ) u_lane (
      .clk_i      (CLK),
      .clr_i      (SYNC_RST),
      .shift_en_i (advance),
      .head_i     (head[i]),
      .tail_o     (tail[i])
    );
  end

  always_comb begin
    for (int i = 0; i < LENGTH; i++) begin
      Out_Data[i] = tail[i];
    end
  end

  assign Out_Valid = out_valid_q;
  assign Done      = done_q;
  assign Busy      = (state_q != IDLE);

endmodule

// File: tb/tb_systolic_input_skewer.sv
// Bench for systolic_input_skewer (WIDTH=8, LENGTH=4): directed scenarios with literal
// expectations, then random traffic, all checked against a history-based reference model.
module tb_systolic_input_skewer;

  localparam int W = 8;
  localparam int L = 4;

  typedef logic [0:L-1][W-1:0] vec_t;

  logic CLK = 1'b0;
  logic SYNC_RST;
  logic In_Valid, In_Ready, In_Last, Stall;
  vec_t In_Data, Out_Data;
  logic Out_Valid, Busy, Done;

  int n_checks = 0;
  int n_fail   = 0;

  systolic_input_skewer #(.WIDTH(W), .LENGTH(L)) dut (
    .CLK      (CLK),
    .SYNC_RST (SYNC_RST),
    .In_Valid (In_Valid),
    .In_Ready (In_Ready),
    .In_Last  (In_Last),
    .In_Data  (In_Data),
    .Stall    (Stall),
    .Out_Data (Out_Data),
    .Out_Valid(Out_Valid),
    .Busy     (Busy),
    .Done     (Done)
  );

  always #5 CLK = ~CLK;

  // Reference model: Out_Data[i] is the head vector pushed i advances before the
  // newest one (zero if fewer advances happened since reset).
  vec_t hist[$];
  int   m_mode;       // 0 idle, 1 stream, 2 drain
  int   m_left;       // advances still needed until the last element exits the deepest lane
  logic m_ov, m_done;
  logic model_ok = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_step(input logic v, input logic l, input vec_t d, input logic s, input logic r);
    logic rdy, acc, adv;
    rdy = !s && (m_mode != 2);
    acc = v && rdy;
    adv = acc || (m_mode == 2 && !s);
    if (r) begin
      hist.delete();
      m_mode = 0; m_left = 0; m_ov = 0; m_done = 0;
      model_ok = 1'b1;
    end else begin
      m_ov   = adv;
      m_done = 1'b0;
      if (adv) begin
        hist.push_back(acc ? d : vec_t'(0));
        if (hist.size() > L) void'(hist.pop_front());
      end
      if (acc) begin
        if (!l) m_mode = 1;
        else begin
          m_left = L - 1;
          if (m_left == 0) begin m_mode = 0; m_done = 1'b1; end
          else m_mode = 2;
        end
      end else if (adv) begin
        m_left--;
        if (m_left == 0) begin m_mode = 0; m_done = 1'b1; end
      end
    end
  endtask

  task automatic chk_outputs();
    vec_t h;
    logic [W-1:0] e;
    if (!model_ok) return;
    for (int i = 0; i < L; i++) begin
      e = '0;
      if (hist.size() > i) begin
        h = hist[hist.size()-1-i];
        e = h[i];
      end
      chk($sformatf("out_data[%0d]", i), 32'(Out_Data[i]), 32'(e));
    end
    chk("out_valid", 32'(Out_Valid), 32'(m_ov));
    chk("done", 32'(Done), 32'(m_done));
    chk("busy", 32'(Busy), 32'(m_mode != 0));
  endtask

  // One clock cycle: drive inputs, check ready, advance model, then check outputs.
  task automatic step(input logic v, input logic l, input vec_t d, input logic s, input logic r);
    In_Valid = v; In_Last = l; In_Data = d; Stall = s; SYNC_RST = r;
    #1;
    if (model_ok) chk("in_ready", 32'(In_Ready), 32'(!s && m_mode != 2));
    model_step(v, l, d, s, r);
    @(posedge CLK);
    @(negedge CLK);
    chk_outputs();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, vec_t'(0), 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, vec_t'(0), 1'b0, 1'b1);
    step(1'b0, 1'b0, vec_t'(0), 1'b0, 1'b1);
    step(1'b0, 1'b0, vec_t'(0), 1'b0, 1'b0);
  endtask

  initial begin
    In_Valid = 0; In_Last = 0; In_Data = '0; Stall = 0; SYNC_RST = 0;
    m_mode = 0; m_left = 0; m_ov = 0; m_done = 0;

    // 1. reset
    step(1'b0, 1'b0, vec_t'(0), 1'b0, 1'b1);
    step(1'b0, 1'b0, vec_t'(0), 1'b0, 1'b1);
    chk("rst_data", Out_Data, 32'h0);
    chk("rst_ov", 32'(Out_Valid), 32'h0);
    chk("rst_done", 32'(Done), 32'h0);
    chk("rst_busy", 32'(Busy), 32'h0);
    SYNC_RST = 0; #1;
    chk("rst_ready", 32'(In_Ready), 32'h1);
    @(negedge CLK);

    // 2. single last vector
    step(1'b1, 1'b1, vec_t'(32'h01020304), 1'b0, 1'b0);
    chk("s2_c1_data", Out_Data, 32'h01000000);
    chk("s2_c1_ready", 32'(In_Ready), 32'h0);
    idle(1); chk("s2_c2_data", Out_Data, 32'h00020000);
    idle(1); chk("s2_c3_data", Out_Data, 32'h00000300);
    chk("s2_c3_done", 32'(Done), 32'h0);
    idle(1); chk("s2_c4_data", Out_Data, 32'h00000004);
    chk("s2_c4_done", 32'(Done), 32'h1);
    chk("s2_c4_busy", 32'(Busy), 32'h0);
    chk("s2_c4_ov", 32'(Out_Valid), 32'h1);
    idle(2);

    // 3. back-to-back
    step(1'b1, 1'b0, vec_t'(32'h0A0B0C0D), 1'b0, 1'b0);
    step(1'b1, 1'b1, vec_t'(32'h14151617), 1'b0, 1'b0);
    chk("s3_c2_data", Out_Data, 32'h140B0000);
    idle(1); chk("s3_c3_data", Out_Data, 32'h00150C00);
    idle(1); chk("s3_c4_data", Out_Data, 32'h0000160D);
    idle(1); chk("s3_c5_lane3", 32'(Out_Data[3]), 32'd23);
    chk("s3_c5_done", 32'(Done), 32'h1);
    idle(2);

    // 4. stall during drain
    step(1'b1, 1'b1, vec_t'(32'h01020304), 1'b0, 1'b0);
    idle(1);
    step(1'b0, 1'b0, vec_t'(0), 1'b1, 1'b0);
    chk("s4_c3_data", Out_Data, 32'h00020000);
    chk("s4_c3_ov", 32'(Out_Valid), 32'h0);
    step(1'b0, 1'b0, vec_t'(0), 1'b1, 1'b0);
    chk("s4_c4_data", Out_Data, 32'h00020000);
    chk("s4_c4_done", 32'(Done), 32'h0);
    idle(1); chk("s4_c5_done", 32'(Done), 32'h0);
    idle(1); chk("s4_c6_done", 32'(Done), 32'h1);
    chk("s4_c6_data", Out_Data, 32'h00000004);
    idle(2);

    // 5. reset mid-drain
    step(1'b1, 1'b1, vec_t'(32'h01020304), 1'b0, 1'b0);
    idle(1);
    step(1'b0, 1'b0, vec_t'(0), 1'b0, 1'b1);
    chk("s5_c3_data", Out_Data, 32'h0);
    chk("s5_c3_busy", 32'(Busy), 32'h0);
    SYNC_RST = 0; #1;
    chk("s5_c3_ready", 32'(In_Ready), 32'h1);
    @(negedge CLK);
    for (int k = 0; k < 5; k++) begin
      idle(1);
      chk("s5_no_done", 32'(Done), 32'h0);
    end

    // 6. stream gap
    step(1'b1, 1'b0, vec_t'(32'h05060708), 1'b0, 1'b0);
    chk("s6_c1_busy", 32'(Busy), 32'h1);
    idle(1);
    chk("s6_c2_ov", 32'(Out_Valid), 32'h0);
    chk("s6_c2_data", Out_Data, 32'h05000000);
    step(1'b0, 1'b1, vec_t'(32'hFFFFFFFF), 1'b0, 1'b0);
    chk("s6_c3_ov", 32'(Out_Valid), 32'h0);
    chk("s6_c3_data", Out_Data, 32'h05000000);
    chk("s6_c3_busy", 32'(Busy), 32'h1);
    step(1'b1, 1'b1, vec_t'(32'h090A0B0C), 1'b0, 1'b0);
    idle(5);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 9) < 6, $urandom_range(0, 4) == 0, vec_t'($urandom),
           $urandom_range(0, 4) == 0, $urandom_range(0, 63) == 0);
    end
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
